alu_exec_ctrl: RTL

- Execution stage that sits directly downstream of FIFO_IN and upstream of FIFO_OUT in the APB ALU subsystem.
- Pops one packed command {opcode, operand A, operand B} from FIFO_IN and executes it.
- Single-cycle ops complete in one cycle; multiply is an iterative shift-add.
- Pushes {err, result} into FIFO_OUT, which the APB CSR reads back through REG_RES.

---
 rtl/alu_exec_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_ctrl.sv
// Execution stage of the APB ALU: pops {op, a, b} from FIFO_IN, executes it
// (iterative shift-add for MUL), and pushes {err, result} into FIFO_OUT.
module alu_exec_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int OP_SIZE   = 4,
    parameter int CMD_SIZE  = OP_SIZE + 2*DATA_SIZE,
    parameter int OUT_SIZE  = 2*DATA_SIZE + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                empty_in,
    input  logic [CMD_SIZE-1:0] data_in,
    output logic                r_en_in,
    input  logic                full_out,
    output logic                w_en_out,
    output logic [OUT_SIZE-1:0] data_out,
    output logic                busy,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_EXEC = 3'd3,
        ST_PUSH = 3'd4
    } state_t;

    localparam int RES_W = 2*DATA_SIZE;
    localparam int CNT_W = $clog2(DATA_SIZE + 1);

    localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_MUL = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] OP_SHL = OP_SIZE'(6);
    localparam logic [OP_SIZE-1:0] OP_SHR = OP_SIZE'(7);

    state_t                 r_state;
    logic [OP_SIZE-1:0]     r_op;
    logic [DATA_SIZE-1:0]   r_a;
    logic [DATA_SIZE-1:0]   r_b;
    logic [RES_W-1:0]       r_res;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [RES_W-1:0]       r_acc;
    logic [RES_W-1:0]       r_mcand;
    logic [DATA_SIZE-1:0]   r_mplier;

    logic [OP_SIZE-1:0]     w_op;
    logic [DATA_SIZE-1:0]   w_a;
    logic [DATA_SIZE-1:0]   w_b;
    logic [DATA_SIZE:0]     w_sum;
    logic [DATA_SIZE:0]     w_diff;
    logic [DATA_SIZE-1:0]   w_shamt;
    logic [RES_W-1:0]       w_res;
    logic                   w_err;
    logic                   w_mul_done;

    assign w_op  = data_in[CMD_SIZE-1 -: OP_SIZE];
    assign w_a   = data_in[2*DATA_SIZE-1 -: DATA_SIZE];
    assign w_b   = data_in[DATA_SIZE-1:0];

    // SUB wraps modulo 2^(DATA_SIZE+1), so the top bit reads as the borrow.
    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt = DATA_SIZE'(r_b % DATA_SIZE);

    // MUL spends DATA_SIZE cycles on shift-add steps plus one cycle to retire the product.
    assign w_mul_done  = (r_cnt == CNT_W'(DATA_SIZE));
    assign o_dbg_state = r_state;

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_op)
            OP_ADD:  w_res = {{(RES_W-DATA_SIZE-1){1'b0}}, w_sum};
            OP_SUB:  w_res = {{(RES_W-DATA_SIZE-1){1'b0}}, w_diff};
            OP_AND:  w_res = {{DATA_SIZE{1'b0}}, r_a & r_b};
            OP_OR:   w_res = {{DATA_SIZE{1'b0}}, r_a | r_b};
            OP_XOR:  w_res = {{DATA_SIZE{1'b0}}, r_a ^ r_b};
            OP_MUL:  w_res = r_acc;
            OP_SHL:  w_res = {{DATA_SIZE{1'b0}}, r_a} << w_shamt;
            OP_SHR:  w_res = {{DATA_SIZE{1'b0}}, r_a >> w_shamt};
            default: w_err = 1'b1;
        endcase
    end

    // Handshake: r_en_in is a one-cycle pop issued only after empty_in=0 was seen in IDLE,
    // with data_in valid the following cycle; w_en_out is a one-cycle push issued only
    // after full_out=0 was seen in PUSH, and data_out holds its value until the next push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_en_in  <= 1'b0;
            w_en_out <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
        end else begin
            r_en_in  <= 1'b0;
            w_en_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!empty_in) begin
                        r_state <= ST_POP;
                        r_en_in <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_POP: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_op     <= w_op;
                    r_a      <= w_a;
                    r_b      <= w_b;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_mcand  <= {{DATA_SIZE{1'b0}}, w_a};
                    r_mplier <= w_b;
                    r_state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_op == OP_MUL) begin
                        if (w_mul_done) begin
                            r_res   <= r_acc;
                            r_err   <= 1'b0;
                            r_state <= ST_PUSH;
                        end else begin
                            if (r_mplier[0]) begin
                                r_acc <= r_acc + r_mcand;
                            end
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= r_mplier >> 1;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_res   <= w_res;
                        r_err   <= w_err;
                        r_state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (!full_out) begin
                        w_en_out <= 1'b1;
                        data_out <= {r_err, r_res};
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
